// File: rtl/sccb_pkg.sv
// Shared types, markers and register ROM contents for the OV7670 SCCB config master.
package sccb_pkg;

  // One ROM word: camera register address and the value written to it
  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] val;
  } rom_entry_t;

  localparam rom_entry_t SCCB_END   = 16'hFFFF;
  localparam rom_entry_t SCCB_DELAY = 16'hF0F0;

  typedef enum logic [2:0] {
    ST_IDLE, ST_FETCH, ST_SEND, ST_WAITTX, ST_DELAY, ST_DONE
  } seq_state_t;

  typedef enum logic [2:0] {
    PH_IDLE, PH_S0, PH_S1, PH_BIT, PH_P0, PH_P1, PH_P2
  } phy_state_t;

  // Camera bring-up: soft reset, settle, then RGB565 output with /2 pixel clock
  function automatic rom_entry_t sccb_rom(input logic [7:0] idx);
    case (idx)
      8'd0:    return 16'h1280;  // COM7: register reset
      8'd1:    return SCCB_DELAY;
      8'd2:    return 16'h1204;  // COM7: RGB output
      8'd3:    return 16'h40D0;  // COM15: RGB565, full range
      8'd4:    return 16'h8C00;  // RGB444 off
      8'd5:    return 16'h1101;  // CLKRC: prescale /2
      8'd6:    return 16'h3A04;  // TSLB
      8'd7:    return 16'h3DC0;  // COM13: gamma + UV saturation
      8'd8:    return 16'h0C00;  // COM3
      8'd9:    return 16'h3E00;  // COM14: no PCLK scaling
      default: return SCCB_END;
    endcase
  endfunction

  // Short sequence used for bring-up of the sequencer itself
  function automatic rom_entry_t sccb_test_rom(input logic [7:0] idx);
    case (idx)
      8'd0:    return 16'h1280;
      8'd1:    return SCCB_DELAY;
      8'd2:    return 16'h1204;
      default: return SCCB_END;
    endcase
  endfunction

endpackage

// File: rtl/sccb_write_phy.sv
// SCCB 3-phase write frame generator: START, 3 x (8 data + don't-care), STOP.
// All bus timing is expressed in quarter-bit periods delivered by qtick.
module sccb_write_phy
  import sccb_pkg::*;
(
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        qtick,
  input  logic        tx_go,
  input  logic [23:0] frame,
  input  logic        siod_in,
  output logic        sioc,
  output logic        siod_oe,
  output logic        tx_done,
  output logic        nack_pulse
);

  phy_state_t  st;
  logic [1:0]  qq;       // quarter within the current bit
  logic [4:0]  bit_cnt;  // 0..26 across the whole frame
  logic [23:0] sh;       // remaining data bits, MSB goes out next
  logic        cur_dc, nxt_dc;
  logic [23:0] sh_nxt;

  // Don't-care slots are bits 8, 17 and 26; only data bits consume the shifter
  always_comb begin
    cur_dc = (bit_cnt == 5'd8) || (bit_cnt == 5'd17) || (bit_cnt == 5'd26);
    nxt_dc = (bit_cnt == 5'd7) || (bit_cnt == 5'd16) || (bit_cnt == 5'd25);
    sh_nxt = cur_dc ? sh : {sh[22:0], 1'b0};
  end

  // Frame sequencer; SIOD only moves at Q0 (with SIOC low) apart from START/STOP
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      st         <= PH_IDLE;
      qq         <= 2'd0;
      bit_cnt    <= 5'd0;
      sh         <= 24'd0;
      sioc       <= 1'b1;
      siod_oe    <= 1'b0;
      tx_done    <= 1'b0;
      nack_pulse <= 1'b0;
    end else begin
      tx_done    <= 1'b0;
      nack_pulse <= 1'b0;
      case (st)
        PH_IDLE: if (tx_go) begin
          st      <= PH_S0;
          sh      <= frame;
          bit_cnt <= 5'd0;
          qq      <= 2'd0;
          sioc    <= 1'b1;
          siod_oe <= 1'b1;
        end
        PH_S0: if (qtick) begin
          st   <= PH_S1;
          sioc <= 1'b0;
        end
        PH_S1: if (qtick) begin
          st      <= PH_BIT;
          qq      <= 2'd0;
          siod_oe <= ~sh[23];
        end
        PH_BIT: if (qtick) begin
          qq <= qq + 2'd1;
          case (qq)
            2'd1: sioc <= 1'b1;
            2'd2: if (cur_dc && siod_in) nack_pulse <= 1'b1;
            2'd3: begin
              sioc <= 1'b0;
              sh   <= sh_nxt;
              if (bit_cnt == 5'd26) begin
                st      <= PH_P0;
                siod_oe <= 1'b1;
              end else begin
                bit_cnt <= bit_cnt + 5'd1;
                siod_oe <= nxt_dc ? 1'b0 : ~sh_nxt[23];
              end
            end
            default: ;
          endcase
        end
        PH_P0: if (qtick) begin
          st   <= PH_P1;
          sioc <= 1'b1;
        end
        PH_P1: if (qtick) begin
          st      <= PH_P2;
          siod_oe <= 1'b0;
        end
        PH_P2: if (qtick) begin
          st      <= PH_IDLE;
          tx_done <= 1'b1;
        end
        default: st <= PH_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/ov7670_sccb_cfg.sv
// OV7670 configuration master: walks the register ROM and writes each entry
// to the camera over SCCB. Holds the quarter-tick divider and the sequencer.
module ov7670_sccb_cfg
  import sccb_pkg::*;
#(
  parameter int         CLK_HZ   = 50_000_000,
  parameter int         SCCB_HZ  = 100_000,
  parameter logic [7:0] DEV_ADDR = 8'h42,
  parameter int         DELAY_MS = 10,
  parameter bit         TEST_ROM = 1'b0
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       nack,
  output logic [7:0] reg_idx,
  output logic       sioc,
  output logic       siod_oe,
  input  logic       siod_in
);

  localparam int QDIV     = CLK_HZ / (4 * SCCB_HZ);
  localparam int QW       = (QDIV > 1) ? $clog2(QDIV) : 1;
  localparam int DLY_CYC  = DELAY_MS * (CLK_HZ / 1000);
  localparam int DLY_LAST = (DLY_CYC > 0) ? DLY_CYC - 1 : 0;

  seq_state_t  st;
  logic [QW-1:0] q_cnt;
  logic        q_wrap, qtick;
  logic        accept;
  logic        tx_go, tx_done, nack_pulse;
  logic        gap_act;
  logic [1:0]  gap_cnt;
  logic [31:0] dly_cnt;
  rom_entry_t  rom_q;

  assign q_wrap = (q_cnt == QW'(QDIV - 1));
  assign accept = start && (st == ST_IDLE);
  assign rom_q  = TEST_ROM ? sccb_test_rom(reg_idx) : sccb_rom(reg_idx);

  // Quarter-bit divider: runs only while busy, phase restarts on every start
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      q_cnt <= '0;
      qtick <= 1'b0;
    end else if (accept) begin
      q_cnt <= '0;
      qtick <= 1'b0;
    end else if (busy) begin
      q_cnt <= q_wrap ? '0 : q_cnt + 1'b1;
      qtick <= q_wrap;
    end else begin
      qtick <= 1'b0;
    end
  end

  // ROM walker. tx_go is launched one cycle ahead of a qtick so START gets a full quarter.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      st      <= ST_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      nack    <= 1'b0;
      reg_idx <= 8'd0;
      tx_go   <= 1'b0;
      gap_act <= 1'b0;
      gap_cnt <= 2'd0;
      dly_cnt <= 32'd0;
    end else begin
      tx_go <= 1'b0;
      if (nack_pulse) nack <= 1'b1;
      case (st)
        ST_IDLE: if (start) begin
          reg_idx <= 8'd0;
          done    <= 1'b0;
          nack    <= 1'b0;
          busy    <= 1'b1;
          st      <= ST_FETCH;
        end
        ST_FETCH: begin
          if (rom_q == SCCB_END) st <= ST_DONE;
          else if (rom_q == SCCB_DELAY) begin
            dly_cnt <= 32'd0;
            st      <= ST_DELAY;
          end else st <= ST_SEND;
        end
        ST_SEND: if (q_wrap) begin
          tx_go   <= 1'b1;
          gap_act <= 1'b0;
          gap_cnt <= 2'd0;
          st      <= ST_WAITTX;
        end
        ST_WAITTX: begin
          if (!gap_act) begin
            if (tx_done) gap_act <= 1'b1;
          end else if (qtick) begin
            if (gap_cnt == 2'd3) begin
              reg_idx <= reg_idx + 8'd1;
              st      <= ST_FETCH;
            end else gap_cnt <= gap_cnt + 2'd1;
          end
        end
        ST_DELAY: begin
          if (dly_cnt >= 32'(DLY_LAST)) begin
            reg_idx <= reg_idx + 8'd1;
            st      <= ST_FETCH;
          end else dly_cnt <= dly_cnt + 32'd1;
        end
        ST_DONE: begin
          done <= 1'b1;
          busy <= 1'b0;
          st   <= ST_IDLE;
        end
        default: st <= ST_IDLE;
      endcase
    end
  end

  sccb_write_phy u_phy (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .qtick      (qtick),
    .tx_go      (tx_go),
    .frame      ({DEV_ADDR, rom_q}),
    .siod_in    (siod_in),
    .sioc       (sioc),
    .siod_oe    (siod_oe),
    .tx_done    (tx_done),
    .nack_pulse (nack_pulse)
  );

endmodule

// File: tb/tb_ov7670_sccb_cfg.sv
// Directed bench: two configurations (full ROM with delay, short test ROM with
// zero delay) watched by a bus decoder that rebuilds each 27-bit frame.
module tb_ov7670_sccb_cfg;

  localparam int CLK_HZ = 3_200_000;
  localparam int Q      = CLK_HZ / (4 * 100_000);   // 8 cycles per quarter
  localparam int N      = 1 * (CLK_HZ / 1000);       // 1 ms delay entry

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  logic start_m = 1'b0, start_t = 1'b0;
  logic siod_in = 1'b0, siod_t = 1'b0;

  logic m_busy, m_done, m_nack, m_sioc, m_oe;
  logic t_busy, t_done, t_nack, t_sioc, t_oe;
  logic [7:0] m_idx, t_idx;

  int vecs = 0;
  int errs = 0;
  int cyc = 0;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  ov7670_sccb_cfg #(
    .CLK_HZ(CLK_HZ), .SCCB_HZ(100_000), .DEV_ADDR(8'h42), .DELAY_MS(1), .TEST_ROM(1'b0)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .start(start_m), .busy(m_busy), .done(m_done),
    .nack(m_nack), .reg_idx(m_idx), .sioc(m_sioc), .siod_oe(m_oe), .siod_in(siod_in)
  );

  ov7670_sccb_cfg #(
    .CLK_HZ(CLK_HZ), .SCCB_HZ(100_000), .DEV_ADDR(8'h42), .DELAY_MS(0), .TEST_ROM(1'b1)
  ) dut_t (
    .CLK(CLK), .RST_N(RST_N), .start(start_t), .busy(t_busy), .done(t_done),
    .nack(t_nack), .reg_idx(t_idx), .sioc(t_sioc), .siod_oe(t_oe), .siod_in(siod_t)
  );

  // Bus decoder: index 0 watches dut, index 1 watches dut_t
  logic [1:0]  sioc_v, oe_v;
  logic [1:0]  ps = 2'b11, po = 2'b00;
  int          nst[2], nfrm[2], bits[2];
  logic [26:0] sr[2];
  logic [23:0] frm[2][16];
  int          st_t[2][16], sp_t[2][16];

  assign sioc_v = {t_sioc, m_sioc};
  assign oe_v   = {t_oe, m_oe};

  initial begin
    for (int i = 0; i < 2; i++) begin
      nst[i] = 0; nfrm[i] = 0; bits[i] = 0; sr[i] = '0;
    end
  end

  always @(posedge CLK) begin
    #1;
    for (int i = 0; i < 2; i++) begin
      if (ps[i] && sioc_v[i] && !po[i] && oe_v[i]) begin
        st_t[i][nst[i] % 16] = cyc;
        nst[i] = nst[i] + 1;
        bits[i] = 0;
      end else if (ps[i] && sioc_v[i] && po[i] && !oe_v[i]) begin
        // 27 frame bits plus the SIOC rise into P1 make a complete frame
        if (bits[i] == 28) begin
          sp_t[i][nfrm[i] % 16] = cyc;
          frm[i][nfrm[i] % 16]  = {sr[i][26:19], sr[i][17:10], sr[i][8:1]};
          nfrm[i] = nfrm[i] + 1;
        end
        bits[i] = 0;
      end else if (!ps[i] && sioc_v[i]) begin
        if (bits[i] < 27) sr[i] = {sr[i][25:0], ~oe_v[i]};
        bits[i] = bits[i] + 1;
      end
    end
    ps = sioc_v;
    po = oe_v;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
    vecs++;
    assert (obs >= lo && obs <= hi) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic pulse(input int which);
    if (which == 0) start_m = 1'b1; else start_t = 1'b1;
    @(negedge CLK);
    start_m = 1'b0;
    start_t = 1'b0;
  endtask

  initial begin
    // Reset then idle
    repeat (10) @(negedge CLK);
    RST_N = 1'b1;
    repeat (1000) @(negedge CLK);
    chk("idle_sioc", m_sioc, 1);
    chk("idle_oe", m_oe, 0);
    chk("idle_busy", m_busy, 0);
    chk("idle_done", m_done, 0);
    chk("idle_nack", m_nack, 0);
    chk("idle_idx", m_idx, 0);
    chk("idle_t_sioc", t_sioc, 1);

    // First frame
    pulse(0);
    chk("busy_after_start", m_busy, 1);
    for (int i = 0; i < 3000 && nfrm[0] < 1; i++) @(negedge CLK);
    chk("f1_seen", nfrm[0], 1);
    chk("f1_bytes", frm[0][0], 24'h421280);
    chk("f1_start_to_stop", sp_t[0][0] - st_t[0][0], 112 * Q);
    chk("f1_nack", m_nack, 0);

    // Delay entry: end of P2 to the next START
    for (int i = 0; i < 10000 && nst[0] < 2; i++) @(negedge CLK);
    chk("f2_started", nst[0], 2);
    chk_rng("delay_gap", st_t[0][1] - (sp_t[0][0] + Q), N + 3 * Q, N + 5 * Q + 4);
    chk("idx_after_delay", m_idx, 2);

    // Don't-care sampling: SIOD high only across the 2nd don't-care bit of frame 3
    for (int i = 0; i < 5000 && !(nst[0] == 3 && bits[0] == 17 && !m_sioc); i++) @(negedge CLK);
    chk("dc2_reached", (nst[0] == 3 && bits[0] == 17), 1);
    chk("nack_before_dc2", m_nack, 0);
    siod_in = 1'b1;
    for (int i = 0; i < 100 && !(bits[0] == 18 && !m_sioc); i++) @(negedge CLK);
    siod_in = 1'b0;
    chk("nack_after_dc2", m_nack, 1);

    // A start while busy must not restart or clear anything
    pulse(0);
    for (int i = 0; i < 20000 && !m_done; i++) @(negedge CLK);
    chk("full_done", m_done, 1);
    chk("full_busy", m_busy, 0);
    chk("full_nack_sticky", m_nack, 1);
    chk("full_idx", m_idx, 10);
    chk("full_nframes", nfrm[0], 9);
    chk("f2_bytes", frm[0][1], 24'h421204);
    chk("f3_bytes", frm[0][2], 24'h4240D0);
    chk("f9_bytes", frm[0][8], 24'h423E00);

    // Short test ROM, zero delay
    pulse(1);
    for (int i = 0; i < 5000 && !t_done; i++) @(negedge CLK);
    chk("t_done", t_done, 1);
    chk("t_busy", t_busy, 0);
    chk("t_idx", t_idx, 3);
    chk("t_nframes", nfrm[1], 2);
    chk("t_f1", frm[1][0], 24'h421280);
    chk("t_f2", frm[1][1], 24'h421204);
    pulse(1);
    chk("t_done_cleared", t_done, 0);
    chk("t_busy_again", t_busy, 1);
    for (int i = 0; i < 5000 && !t_done; i++) @(negedge CLK);
    chk("t_redone", t_done, 1);
    chk("t_nframes2", nfrm[1], 4);
    chk("t_f4", frm[1][3], 24'h421204);

    // Reset mid-frame: byte 2, bit 4 (a 0 bit, so SIOD is pulled low)
    pulse(0);
    chk("rst_test_done_cleared", m_done, 0);
    for (int i = 0; i < 3000 && !(nst[0] == 10 && bits[0] == 14 && m_sioc); i++) @(negedge CLK);
    chk("rst_point_reached", (nst[0] == 10 && bits[0] == 14), 1);
    chk("oe_before_rst", m_oe, 1);
    RST_N = 1'b0;
    #1;
    chk("rst_sioc", m_sioc, 1);
    chk("rst_oe", m_oe, 0);
    chk("rst_busy", m_busy, 0);
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    repeat (5) @(negedge CLK);
    pulse(0);
    for (int i = 0; i < 3000 && nfrm[0] < 10; i++) @(negedge CLK);
    chk("post_rst_nframes", nfrm[0], 10);
    chk("post_rst_bytes", frm[0][9], 24'h421280);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/ov7670_sccb_cfg.md
# ov7670_sccb_cfg

- SCCB (I2C-like, write-only) configuration master for the OV7670 camera on the Arduino header.
- On `start` it walks an internal register ROM and writes every `{reg, value}` pair to device address `DEV_ADDR` over SIOC/SIOD.
- It is the transmitting counterpart of the camera pixel receive path: the receive path consumes the camera's output, and this block programs the camera's mode (RGB565, clocking) before that output is valid.
- It sits at the top level beside the camera reader. It drives `ARDUINO_IO[15]` (SIOC) and `ARDUINO_IO[14]` (SIOD, open-drain).

## Interface
Parameters:
- `CLK_HZ`, 50_000_000: frequency of CLK.
- `SCCB_HZ`, 100_000: SIOC bit rate.
- `DEV_ADDR`, 8'h42: 8-bit write address (R/W bit = 0).
- `DELAY_MS`, 10: wait inserted by a ROM delay entry.

Ports:
- `CLK` in 1: system clock, MAX10_CLK1_50.
- `RST_N` in 1: asynchronous, active-low reset.
- `start` in 1: single-cycle pulse; begins the configuration sequence from ROM index 0.
- `busy` out 1: high from the cycle after an accepted `start` until `done` rises.
- `done` out 1: sticky high after the end entry is reached; cleared by the next accepted `start`.
- `nack` out 1: sticky high if any don't-care (9th) bit was sampled as 1; cleared by an accepted `start`.
- `reg_idx` out 8: ROM index currently being sent.
- `sioc` out 1: SCCB clock, push-pull.
- `siod_oe` out 1: 1 pulls SIOD low; 0 releases it (pulled up externally).
- `siod_in` in 1: sampled SIOD line.

## Operation
- Quarter tick: a counter wraps at `CLK_HZ/(4*SCCB_HZ)` (125 at the defaults) and emits a 1-cycle `qtick`. The counter is free-running only while `busy`; it reloads to 0 on an accepted `start`.
- ROM: 16-bit entries `{reg[7:0], val[7:0]}`, up to 256 entries.
  - `16'hFFFF` marks the end of the sequence.
  - `16'hF0F0` inserts a delay of `DELAY_MS`.
  - Entry 0 is `16'h1280` (COM7 reset). Entry 1 is `16'hF0F0`.
- Sequencer states:
  - IDLE: on `start`, set `reg_idx`=0, clear `done`/`nack`, go to FETCH.
  - FETCH (1 cycle): end entry goes to DONE; delay entry goes to DELAY; any other entry goes to SEND.
  - SEND: pulse `tx_go` to the phy, go to WAITTX.
  - WAITTX: on `tx_done`, wait a 4-qtick gap, then increment `reg_idx` and go to FETCH.
  - DELAY: count `DELAY_MS*CLK_HZ/1000` cycles, then increment `reg_idx` and go to FETCH.
  - DONE: set `done`, drop `busy`, go to IDLE.
- Phy frame: 3 bytes in order `DEV_ADDR`, `reg`, `val`. Each byte is 8 data bits MSB-first followed by 1 don't-care bit, for 27 bits total.
- Bit encoding: data bit 1 gives `siod_oe`=0; data bit 0 gives `siod_oe`=1. During the don't-care bit `siod_oe`=0.
- `start` while `busy` is ignored.

## Timing
- Reset values: `sioc`=1, `siod_oe`=0, `busy`=0, `done`=0, `nack`=0, `reg_idx`=0. The sequencer and phy are both idle.
- Start condition, 2 quarters:
  - S0: `sioc`=1, `siod_oe`=1.
  - S1: `sioc`=0, `siod_oe`=1.
- Each bit is 4 quarters:
  - Q0 and Q1: `sioc`=0. `siod_oe` is updated at the start of Q0.
  - Q2 and Q3: `sioc`=1.
  - `siod_in` is sampled on the qtick ending Q2, for don't-care bits only.
- Stop condition, 3 quarters:
  - P0: `sioc`=0, `siod_oe`=1.
  - P1: `sioc`=1, `siod_oe`=1.
  - P2: `sioc`=1, `siod_oe`=0.
- Frame length: 2 + 108 + 3 = 113 quarters, which is 14125 CLK cycles at the defaults. `tx_done` pulses for 1 cycle at the end of P2.
- SIOD never changes while `sioc`=1, except for the START and STOP edges.
- `tx_go` to the first S0 is 1 cycle. S0 itself begins immediately and lasts one full quarter.
- `RST_N` asserted mid-frame: all outputs return to their reset values asynchronously. No stop condition is generated. The next `start` restarts at index 0.
- `reg_idx` wraps 255 to 0 if the ROM has no end entry. This is a ROM bug; the block does not guard against it.

## Structure
- Package `sccb_pkg`:
  - ROM entry type.
  - Constants `SCCB_END`=16'hFFFF and `SCCB_DELAY`=16'hF0F0.
  - Sequencer state enum and phy state enum.
  - ROM contents as a function `sccb_rom(idx)`.
- Sub-module `sccb_write_phy`.
  - Inputs: `CLK`, `RST_N`, `qtick`, `tx_go`, the 24-bit frame, `siod_in`.
  - Outputs: `sioc`, `siod_oe`, `tx_done`, `nack_pulse`.
  - Internally a 2-bit quarter counter, a 5-bit bit counter and a 24-bit shift register.
- The top level `ov7670_sccb_cfg` holds the tick divider, the sequencer FSM, the delay counter and the ROM.

## Test plan
- Reset then idle: hold `RST_N`=0 for 10 cycles, release, wait 1000 cycles. Required: `sioc`=1, `siod_oe`=0, `busy`=0, `done`=0.
- First frame: pulse `start`, keep `siod_in`=0, and decode the bus with a bench SCCB monitor. Required: bytes 42, 12, 80 are observed; the frame lasts 14125 cycles from the first S0 to the end of P2; `nack`=0.
- Delay entry: after the first frame, measure the gap until the next START. Required: 500000 cycles for the `DELAY_MS` wait plus 500 gap cycles (±1 qtick).
- Don't-care sampling: drive `siod_in`=1 only during the 2nd don't-care bit of frame 3. Required: `nack` rises and the sequence continues to `done`=1.
- Full run: use a 4-entry test ROM `{1280, F0F0, 1204, FFFF}` with `DELAY_MS`=0. Required: 2 frames are sent, then `done`=1, `busy`=0 and `reg_idx`=3. A second `start` replays the sequence and clears `done`.
- Reset mid-frame: assert `RST_N`=0 during byte 2, bit 4. Required: `sioc`=1 and `siod_oe`=0 within the same cycle, and a following `start` sends 42 12 80 again.
